// File: rtl/mux_arbiter4.sv
// mux_arbiter4: four-requester round-robin arbiter that drives a mux4x1.
// Optional forced release after TIMEOUT_CYCLES grant cycles: ARB_TIMEOUT_EN.
//
// Parameters:
//   TIMEOUT_CYCLES  max consecutive grant cycles per owner (2..2**CNT_WIDTH)
//   CNT_WIDTH       width of the hold counter
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   synchronous active-high reset
//   request  in   [3:0] per-requester request (bit k -> mux input k)
//   grant    out  [3:0] one-hot grant, zero when no owner
//   select   out  [1:0] owner index, holds last owner while idle
//   enable   out  high while an owner holds the mux
//   busy     out  high in GRANT state
//   timeout  out  one-cycle pulse after a forced release

module mux_arbiter4 #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] request,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       enable,
    output logic       busy,
    output logic       timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 2**CNT_WIDTH) begin : g_chk
        $error("mux_arbiter4: TIMEOUT_CYCLES out of range");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;

    logic [1:0] winner;
    logic [1:0] scan_idx;
    logic       found;
    logic       expire;

    // Round-robin scan: first set request bit at ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        winner   = ptr_q;
        scan_idx = ptr_q;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr_q + 2'(i);
            if (!found && request[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX =
        CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    // Counter value equals the number of grant cycles already completed,
    // so it reads CNT_MAX during the last allowed cycle.
    assign expire = (cnt_q == CNT_MAX);
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    owner_d = winner;
                    ptr_d   = winner + 2'd1;
                end
            end
            GRANT: begin
                // A voluntary drop wins over an expiring counter.
                if (!request[owner_q] || expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (request[owner_q] && expire) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Outputs come only from flops; requests never reach them directly.
    assign busy   = (state_q == GRANT);
    assign enable = busy;
    assign select = owner_q;
    assign grant  = busy ? (4'b0001 << owner_q) : 4'b0000;

endmodule

// File: tb/tb_mux_arbiter4.sv
// tb_mux_arbiter4: directed self-checking bench for mux_arbiter4.
// Timeout scenarios run only when built with ARB_TIMEOUT_EN.

module tb_mux_arbiter4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [3:0] grant;
    logic [1:0] select;
    logic       enable;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_arbiter4 #(
        .TIMEOUT_CYCLES(16),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .request(request),
        .grant(grant),
        .select(select),
        .enable(enable),
        .busy(busy),
        .timeout(timeout)
    );

    // Advance one edge; outputs are sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        request = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        request = 4'b1111;
        step();
        step();
        checks++;
        if ({grant, select, enable, busy, timeout} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got g=%b s=%0d e=%b b=%b t=%b want all 0",
                     grant, select, enable, busy, timeout);
        end
        reset   = 1'b0;
        request = 4'b0000;
    endtask

    task automatic test_idle_hold();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got g=%b b=%b want 0000 0", grant, busy);
        end
        request = 4'b1111;
        step();
        checks++;
        if (grant !== 4'b0001 || select !== 2'd0) begin
            failures++;
            $display("FAIL idle_ptr got g=%b s=%0d want 0001 0", grant, select);
        end
    endtask

    task automatic test_basic();
        do_reset();
        request = 4'b0101;
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL no_comb_path got g=%b want 0000", grant);
        end
        step();
        checks++;
        if (grant !== 4'b0001 || select !== 2'd0 ||
            enable !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_first got g=%b s=%0d e=%b b=%b want 0001 0 1 1",
                     grant, select, enable, busy);
        end
        step();
        request = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0000 || enable !== 1'b0 || select !== 2'd0) begin
            failures++;
            $display("FAIL basic_gap got g=%b e=%b s=%0d want 0000 0 0",
                     grant, enable, select);
        end
        step();
        checks++;
        if (grant !== 4'b0100 || select !== 2'd2) begin
            failures++;
            $display("FAIL basic_second got g=%b s=%0d want 0100 2", grant, select);
        end
        request = 4'b0000;
        step();
        checks++;
        if (select !== 2'd2 || enable !== 1'b0) begin
            failures++;
            $display("FAIL select_hold got s=%0d e=%b want 2 0", select, enable);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        request = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (grant !== exp_seq[n]) begin
                failures++;
                $display("FAIL rr_grant%0d got %b want %b", n, grant, exp_seq[n]);
            end
            step();
            step();
            request = 4'b1111 & ~exp_seq[n];
            step();
            checks++;
            if (enable !== 1'b0 || grant !== 4'b0000) begin
                failures++;
                $display("FAIL rr_gap%0d got e=%b g=%b want 0 0000", n, enable, grant);
            end
            request = 4'b1111;
        end
        request = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        request = 4'b0010;
        step();
        step();
        step();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL mid_pre got g=%b want 0010", grant);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({grant, select, enable, busy, timeout} !== 9'b0) begin
            failures++;
            $display("FAIL mid_abort got g=%b s=%0d e=%b b=%b t=%b want all 0",
                     grant, select, enable, busy, timeout);
        end
        reset = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0010 || select !== 2'd1) begin
            failures++;
            $display("FAIL mid_regrant got g=%b s=%0d want 0010 1", grant, select);
        end
        // Owner 2 moves ptr to 3; reset must bring it back to 0.
        do_reset();
        request = 4'b0100;
        step();
        do_reset();
        request = 4'b1100;
        step();
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL ptr_reset got g=%b want 0100", grant);
        end
        request = 4'b0000;
    endtask

`ifndef ARB_TIMEOUT_EN
    task automatic test_hold_forever();
        int bad_g = 0;
        int bad_t = 0;
        do_reset();
        request = 4'b1000;
        for (int i = 0; i < 100; i++) begin
            step();
            if (grant !== 4'b1000) bad_g++;
            if (timeout !== 1'b0) bad_t++;
        end
        checks++;
        if (bad_g != 0) begin
            failures++;
            $display("FAIL hold_grant got %0d bad cycles want 0", bad_g);
        end
        checks++;
        if (bad_t != 0) begin
            failures++;
            $display("FAIL hold_timeout got %0d pulses want 0", bad_t);
        end
        request = 4'b0000;
    endtask
`else
    task automatic test_timeout();
        int hi = 0;
        do_reset();
        request = 4'b0011;
        for (int i = 0; i < 40 && hi < 40; i++) begin
            step();
            if (grant == 4'b0001) hi++;
            else break;
        end
        checks++;
        if (hi != 16) begin
            failures++;
            $display("FAIL to_len got %0d cycles want 16", hi);
        end
        checks++;
        if (timeout !== 1'b1 || enable !== 1'b0) begin
            failures++;
            $display("FAIL to_pulse got t=%b e=%b want 1 0", timeout, enable);
        end
        step();
        checks++;
        if (grant !== 4'b0010 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_next got g=%b t=%b want 0010 0", grant, timeout);
        end
        do_reset();
        request = 4'b0100;
        for (int i = 0; i < 17; i++) step();
        checks++;
        if (timeout !== 1'b1 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL to_single got t=%b g=%b want 1 0000", timeout, grant);
        end
        step();
        checks++;
        if (grant !== 4'b0100 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_regrant got g=%b t=%b want 0100 0", grant, timeout);
        end
        // Drop on the last allowed cycle: normal release, no pulse.
        do_reset();
        request = 4'b0001;
        for (int i = 0; i < 16; i++) step();
        request = 4'b0000;
        step();
        checks++;
        if (timeout !== 1'b0 || enable !== 1'b0) begin
            failures++;
            $display("FAIL to_drop got t=%b e=%b want 0 0", timeout, enable);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        request = 4'b0000;
        test_reset();
        test_idle_hold();
        test_basic();
        test_round_robin();
        test_reset_mid_grant();
`ifndef ARB_TIMEOUT_EN
        test_hold_forever();
`else
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
